weight_fetch_sequencer: RTL and testbench



---
 rtl/weight_fetch_sequencer.sv | 173 +++++++++++++++++
 tb/tb_weight_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_sequencer.sv
// Read-side weight store sequencer: fetches one temperature bank per frame and streams it to the
// MAC array through a credit-controlled skid FIFO, holding off and flagging around buffer swaps.
module weight_fetch_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_WEIGHTS = 1554,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            bank_req,
    input  logic                  abort,
    input  logic                  mem_busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]            rd_bank_sel,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last,
    output logic                  frame_done,
    output logic                  frame_torn,
    output logic                  active
);
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int CW = IW + 1;
    localparam int SW = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SWAP, FETCH, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic                    torn;
    logic                    issue_vld;
    logic                    issue_last;
    logic                    data_vld;
    logic                    data_last;
    logic [CW-1:0]           fifo_count;
    logic [FIFO_DEPTH-1:0]   slot_last;
    logic [DATA_WIDTH-1:0]   slot_data [FIFO_DEPTH];

    logic                    pop;
    logic                    push;
    logic                    credit_ok;
    logic                    issue_go;
    logic                    issue_is_last;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [IW-1:0]           wr_idx;
    logic [SW-1:0]           committed;

    assign w_valid = (fifo_count != '0);
    assign w_data  = slot_data[0];
    assign w_last  = slot_last[0];
    assign active  = (state != IDLE);

    assign pop  = w_valid && w_ready;
    assign push = data_vld;

    // A same-cycle pop is deliberately not credited: the FIFO can never be overcommitted.
    assign committed = SW'(fifo_count) + SW'(issue_vld) + SW'(data_vld);
    assign credit_ok = (committed < SW'(FIFO_DEPTH));
    assign wr_idx    = IW'(fifo_count - CW'(pop));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        issue_go   = 1'b0;
        issue_addr = addr_cnt;
        if (!abort && !mem_busy && credit_ok) begin
            case (state)
                IDLE: begin
                    issue_go   = start;
                    issue_addr = '0;
                end
                WAIT_SWAP: begin
                    issue_go   = 1'b1;
                    issue_addr = '0;
                end
                FETCH:   issue_go = 1'b1;
                default: issue_go = 1'b0;
            endcase
        end
    end

    assign issue_is_last = (issue_addr == LAST_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            rd_addr     <= '0;
            rd_bank_sel <= 2'd1;
            torn        <= 1'b0;
            issue_vld   <= 1'b0;
            issue_last  <= 1'b0;
            data_vld    <= 1'b0;
            data_last   <= 1'b0;
            frame_done  <= 1'b0;
            frame_torn  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_torn <= 1'b0;
            issue_vld  <= issue_go;
            data_vld   <= issue_vld;
            data_last  <= issue_last;

            if (abort) begin
                state     <= IDLE;
                issue_vld <= 1'b0;
                data_vld  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rd_bank_sel <= (bank_req == 2'd3) ? 2'd1 : bank_req;
                            torn        <= 1'b0;
                            addr_cnt    <= '0;
                            state       <= mem_busy ? WAIT_SWAP : FETCH;
                        end
                    end
                    WAIT_SWAP: begin
                        if (!mem_busy) state <= FETCH;
                    end
                    FETCH: begin
                        if (mem_busy) torn <= 1'b1;
                    end
                    DRAIN: begin
                        if (pop && w_last) begin
                            frame_done <= 1'b1;
                            frame_torn <= torn;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // Placed after the case so an issue overrides the start-time counter clear.
                if (issue_go) begin
                    rd_addr    <= issue_addr;
                    issue_last <= issue_is_last;
                    if (issue_is_last) state <= DRAIN;
                    else               addr_cnt <= issue_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Tags of unoccupied slots are kept at zero so the head tag is valid after every shift.
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            slot_last  <= '0;
        end else if (abort) begin
            fifo_count <= '0;
            slot_last  <= '0;
        end else begin
            if (pop)  slot_last <= {1'b0, slot_last[FIFO_DEPTH-1:1]};
            if (push) slot_last[wr_idx] <= data_last;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: payload storage has no reset; occupancy and tags alone decide what is valid.
    always_ff @(posedge clk_rd) begin
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) slot_data[i] <= slot_data[i + 1];
        end
        if (push) slot_data[wr_idx] <= rd_data;
    end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: cycle table for the nominal frame, directed swap/abort/reset
// sequences, and randomized frames checked against an address-ordered reference stream.
module tb_weight_fetch_sequencer;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NW = 8;
    localparam int FD = 4;

    logic          clk_rd = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    bank_req;
    logic          abort;
    logic          mem_busy;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_bank_sel;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic          frame_done;
    logic          frame_torn;
    logic          active;

    int n_checks = 0;
    int n_pass   = 0;

    weight_fetch_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_WEIGHTS(NW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_rd     (clk_rd),
        .rst_n      (rst_n),
        .start      (start),
        .bank_req   (bank_req),
        .abort      (abort),
        .mem_busy   (mem_busy),
        .rd_addr    (rd_addr),
        .rd_bank_sel(rd_bank_sel),
        .rd_data    (rd_data),
        .w_data     (w_data),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_last     (w_last),
        .frame_done (frame_done),
        .frame_torn (frame_torn),
        .active     (active)
    );

    always #5 clk_rd = ~clk_rd;

    // Weight store with one-cycle registered read; content is bank*256 + address.
    always @(posedge clk_rd) rd_data <= DW'(int'(rd_bank_sel) * 256 + int'(rd_addr));

    typedef struct {
        logic          start;
        logic [1:0]    bank;
        logic          ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_last;
        logic          exp_done;
        logic          exp_active;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one frame starting now (posedge+1); ready_mode 0 = always, 1 = toggle, 2 = random.
    task automatic run_frame(input logic [1:0] bank, input int ready_mode,
                             input int pre_busy, input int mid_busy);
        logic [DW-1:0] exp_q[$];
        logic [1:0]    eff;
        logic [AW-1:0] hold_addr;
        logic [AW-1:0] frozen_addr;
        int  got = 0, done_cnt = 0, last_cyc = -10, first_valid = -1;
        int  mid_start = -1, max_occ = 0, cyc = 0;
        bit  addr_moved = 0, frozen_bad = 0, finished = 0;
        eff = (bank == 2'd3) ? 2'd1 : bank;
        for (int a = 0; a < NW; a++) exp_q.push_back(DW'(int'(eff) * 256 + a));
        hold_addr   = rd_addr;
        frozen_addr = '0;
        while (!finished && cyc < 300) begin
            start    = (cyc == 0);
            bank_req = bank;
            abort    = 1'b0;
            mem_busy = (cyc < pre_busy) ||
                       (mid_start >= 0 && cyc > mid_start && cyc <= mid_start + mid_busy);
            case (ready_mode)
                0:       w_ready = 1'b1;
                1:       w_ready = (cyc % 2 == 0);
                default: w_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(negedge clk_rd);
            if (cyc == 1) check("bank_sel", 32'(rd_bank_sel), 32'(eff));
            if (cyc >= 1 && cyc <= pre_busy && rd_addr !== hold_addr) addr_moved = 1;
            if (mid_busy > 0 && mid_start < 0 && cyc > pre_busy && rd_addr == AW'(3)) mid_start = cyc;
            if (mid_start >= 0 && cyc == mid_start + 1) frozen_addr = rd_addr;
            if (mid_start >= 0 && cyc > mid_start + 1 && cyc <= mid_start + mid_busy &&
                rd_addr !== frozen_addr) frozen_bad = 1;
            if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
            if (w_valid && first_valid < 0) first_valid = cyc;
            if (w_valid && w_ready) begin
                if (got < NW) begin
                    check("w_data", 32'(w_data), 32'(exp_q[got]));
                    check("w_last", 32'(w_last), 32'(got == NW - 1));
                end
                if (w_last) last_cyc = cyc;
                got++;
            end
            if (frame_done) begin
                done_cnt++;
                check("done_latency", cyc, last_cyc + 1);
                check("frame_torn", 32'(frame_torn), 32'(mid_busy > 0));
                finished = 1;
            end
            cyc++;
            @(posedge clk_rd); #1;
        end
        start    = 1'b0;
        mem_busy = 1'b0;
        w_ready  = 1'b1;
        check("frame_done_seen", done_cnt, 1);
        check("word_count", got, NW);
        check("first_valid", first_valid, pre_busy + 3);
        if (pre_busy > 0) check("wait_addr_hold", 32'(addr_moved), 0);
        if (mid_busy > 0) check("busy_addr_frozen", 32'(frozen_bad), 0);
        check("fifo_occ_bound", 32'(max_occ <= FD), 1);
        check("idle_after", 32'(active), 0);
    endtask

    initial begin
        int n_done;
        int n_valid;

        for (int c = 0; c < 13; c++) begin
            vecs[c].start      = (c == 0);
            vecs[c].bank       = 2'd2;
            vecs[c].ready      = 1'b1;
            vecs[c].exp_valid  = (c >= 3 && c <= 10);
            vecs[c].exp_data   = DW'(16'h200 + c - 3);
            vecs[c].exp_last   = (c == 10);
            vecs[c].exp_done   = (c == 11);
            vecs[c].exp_active = (c >= 1 && c <= 10);
            vecs[c].exp_addr   = (c == 0) ? AW'(0) : AW'((c - 1 > 7) ? 7 : c - 1);
        end

        rst_n = 1'b0; start = 1'b0; bank_req = 2'd0; abort = 1'b0; mem_busy = 1'b0; w_ready = 1'b1;
        repeat (3) @(posedge clk_rd);
        @(negedge clk_rd);
        check("rst_w_valid", 32'(w_valid), 0);
        check("rst_active", 32'(active), 0);
        check("rst_bank_sel", 32'(rd_bank_sel), 1);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_w_last", 32'(w_last), 0);
        rst_n = 1'b1;
        @(posedge clk_rd); #1;

        // Nominal frame, cycle-exact.
        for (int c = 0; c < 13; c++) begin
            start    = vecs[c].start;
            bank_req = vecs[c].bank;
            w_ready  = vecs[c].ready;
            @(negedge clk_rd);
            check($sformatf("t%0d_valid", c), 32'(w_valid), 32'(vecs[c].exp_valid));
            if (vecs[c].exp_valid) check($sformatf("t%0d_data", c), 32'(w_data), 32'(vecs[c].exp_data));
            check($sformatf("t%0d_last", c), 32'(w_last), 32'(vecs[c].exp_last));
            check($sformatf("t%0d_done", c), 32'(frame_done), 32'(vecs[c].exp_done));
            check($sformatf("t%0d_torn", c), 32'(frame_torn), 0);
            check($sformatf("t%0d_active", c), 32'(active), 32'(vecs[c].exp_active));
            check($sformatf("t%0d_addr", c), 32'(rd_addr), 32'(vecs[c].exp_addr));
            @(posedge clk_rd); #1;
        end
        start = 1'b0;

        run_frame(2'd2, 1, 0, 0);   // toggling ready
        run_frame(2'd1, 0, 20, 0);  // swap in progress at start
        run_frame(2'd2, 0, 0, 5);   // swap interrupts the fetch

        // Abort with two words queued.
        start = 1'b1; bank_req = 2'd2; w_ready = 1'b1;
        @(posedge clk_rd); #1;
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            w_ready = (c <= 3);
            abort   = (c == 5);
            @(negedge clk_rd);
            if (c == 5) begin
                check("abort_pre_valid", 32'(w_valid), 1);
                check("abort_pre_count", 32'(dut.fifo_count), 2);
            end
            @(posedge clk_rd); #1;
        end
        abort = 1'b0; w_ready = 1'b1;
        @(negedge clk_rd);
        check("abort_w_valid", 32'(w_valid), 0);
        check("abort_active", 32'(active), 0);
        n_done = 0; n_valid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_rd);
            if (frame_done) n_done++;
            if (w_valid) n_valid++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_no_data", n_valid, 0);
        @(posedge clk_rd); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk_rd); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk_rd);
        check("abort_beats_start", 32'(active), 0);
        @(posedge clk_rd); #1;
        run_frame(2'd0, 0, 0, 0);

        // Asynchronous reset mid-fetch.
        start = 1'b1; bank_req = 2'd2; w_ready = 1'b1;
        @(posedge clk_rd); #1;
        start = 1'b0;
        repeat (3) @(posedge clk_rd);
        #1;
        check("pre_rst_addr", 32'(rd_addr), 3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_w_valid", 32'(w_valid), 0);
        check("arst_w_last", 32'(w_last), 0);
        check("arst_done", 32'(frame_done), 0);
        check("arst_torn", 32'(frame_torn), 0);
        check("arst_active", 32'(active), 0);
        check("arst_addr", 32'(rd_addr), 0);
        check("arst_bank_sel", 32'(rd_bank_sel), 1);
        repeat (2) @(negedge clk_rd);
        rst_n = 1'b1;
        n_done = 0; n_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_rd);
            if (frame_done) n_done++;
            if (w_valid) n_valid++;
        end
        check("post_rst_no_done", n_done, 0);
        check("post_rst_no_data", n_valid, 0);
        @(posedge clk_rd); #1;
        run_frame(2'd3, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            logic [1:0] b;
            int         pre;
            int         mid;
            b   = 2'($urandom_range(0, 3));
            pre = int'($urandom_range(0, 4));
            mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            repeat ($urandom_range(0, 3)) @(posedge clk_rd);
            #1;
            run_frame(b, 2, pre, mid);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
